// File: rtl/mem_access_stage.sv
// Memory-access stage: runs one load or store per instruction against data
// memory over a req/ack handshake, stalls the pipeline while the access is
// outstanding, and returns aligned, extended load data for the ME/WB register.
// Misaligned accesses and bus timeouts are flagged for the exception logic.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] control,
  input  logic [31:0] aluR,
  input  logic [31:0] regTValue,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        addrError,
  output logic        busError
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value before the access is abandoned as a bus error.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        is_load_r;
  logic [1:0]  size_r;
  logic [1:0]  lo_r;
  logic        uns_r;

  logic        mem_read_s;
  logic        mem_write_s;
  logic [1:0]  size_s;
  logic        access_s;
  logic        misaligned_s;
  logic        unused_ctrl_s;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      2'b10:   be = 4'b0001 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] rt);
    logic [31:0] wd;
    case (size)
      2'b01:   wd = {2{rt[15:0]}};
      2'b10:   wd = {4{rt[7:0]}};
      default: wd = rt;
    endcase
    return wd;
  endfunction

  // Select the addressed lane of the read word and sign/zero-extend it.
  function automatic logic [31:0] extract_f(input logic [1:0] size, input logic [1:0] lo,
                                            input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign mem_read_s    = control[0];
  assign mem_write_s   = control[1];
  assign size_s        = control[3:2];
  assign access_s      = mem_read_s | mem_write_s;
  assign unused_ctrl_s = ^control[31:5];

  // Alignment check: words need both low bits clear, halves need bit 0 clear.
  always_comb begin
    misaligned_s = 1'b0;
    case (size_s)
      2'b01:   misaligned_s = aluR[0];
      2'b10:   misaligned_s = 1'b0;
      default: misaligned_s = aluR[1] | aluR[0];
    endcase
  end

  // Stall and misalignment flags depend on the current instruction only in IDLE.
  always_comb begin
    stall     = 1'b0;
    addrError = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          if (misaligned_s) begin
            addrError = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end else begin
          stall = 1'b0;
        end
      end
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Access sequencer: issues the request, waits for ack or timeout, finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      is_load_r <= 1'b0;
      size_r    <= 2'b00;
      lo_r      <= 2'b00;
      uns_r     <= 1'b0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= 32'h0000_0000;
      memWdata  <= 32'h0000_0000;
      memByteEn <= 4'b0000;
      loadData  <= 32'h0000_0000;
      busError  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busError <= 1'b0;
          if (access_s && !misaligned_s) begin
            state_r   <= REQ;
            memReq    <= 1'b1;
            // A read wins when both read and write are set.
            memWe     <= mem_write_s & ~mem_read_s;
            memAddr   <= {aluR[31:2], 2'b00};
            memWdata  <= wdata_f(size_s, regTValue);
            memByteEn <= byte_en_f(size_s, aluR[1:0]);
            cnt_r     <= 8'd0;
            is_load_r <= mem_read_s;
            size_r    <= size_s;
            lo_r      <= aluR[1:0];
            uns_r     <= control[4];
          end
        end
        REQ: begin
          if (memAck) begin
            memReq  <= 1'b0;
            memWe   <= 1'b0;
            state_r <= DONE;
            if (is_load_r) begin
              loadData <= extract_f(size_r, lo_r, uns_r, memRdata);
            end
          end else if (cnt_r == CNT_LAST) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            state_r  <= DONE;
            busError <= 1'b1;
            if (is_load_r) begin
              loadData <= 32'h0000_0000;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          busError <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          memReq   <= 1'b0;
          memWe    <= 1'b0;
          busError <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage CPU pipeline, sitting directly downstream of the EX/ME pipeline register. It takes the latched control word, ALU result (effective address) and rt value, and runs a load or store against data memory over a req/ack handshake. It stalls the pipeline while the access is outstanding and returns aligned, extended load data for the ME/WB register. It also flags misaligned addresses and bus timeouts for the exception logic.

## Interface
- TIMEOUT, 255: REQ-state cycles without memAck before a bus error; legal range 1–255.
- clock  input  1  pipeline clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- control  input  32  EX/ME control word: [0] memRead, [1] memWrite, [3:2] size (00 word, 01 half, 10 byte, 11 word), [4] loadUnsigned; other bits ignored.
- aluR  input  32  effective byte address.
- regTValue  input  32  store data, right-justified.
- memRdata  input  32  read data from memory, valid when memAck = 1.
- memAck  input  1  memory completion strobe.
- memReq  output  1  registered request, held until ack or timeout.
- memWe  output  1  registered write enable, qualified by memReq.
- memAddr  output  32  registered word address: {aluR[31:2], 2'b00}.
- memWdata  output  32  registered lane-replicated store data.
- memByteEn  output  4  registered byte enables; bit i = byte lane i (little-endian).
- loadData  output  32  extended load result; updated only on load completion.
- stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/ME (EX/ME enable = !stall).
- addrError  output  1  combinational misalignment flag.
- busError  output  1  one-cycle timeout flag.

## Operation
- Access = memRead | memWrite. When both bits are set, the stage performs a read and ignores memWrite.
- Alignment rules:
  - Word: misaligned if aluR[1:0] != 0.
  - Half: misaligned if aluR[0] = 1.
  - Byte: never misaligned.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Aligned access: stall = 1. Next state REQ; load memReq = 1, memWe, memAddr, memWdata, memByteEn and clear the timeout counter.
  - Misaligned access: addrError = 1, stall = 0, no request, stay in IDLE.
  - No access: stall = 0, stay in IDLE.
- REQ:
  - stall = 1; memReq and all memory outputs are held stable.
  - memAck = 1: drop memReq and go to DONE. For a load, register the extracted data into loadData.
  - No ack: increment the counter. When the counter reaches TIMEOUT − 1 with no ack, drop memReq, go to DONE with busError set, and clear loadData to 0 if the access is a load.
- DONE:
  - stall = 0 so EX/ME advances; next state is IDLE.
  - busError is high only in this state, and only after a timeout.
  - addrError is 0 in REQ and DONE.
- Store lanes:
  - Byte: wdata = {4{rt[7:0]}}, byteEn = 0001 << aluR[1:0].
  - Half: wdata = {2{rt[15:0]}}, byteEn = 0011 << {aluR[1], 1'b0}.
  - Word: wdata = rt, byteEn = 1111.
- Loads select the lane by aluR[1:0] (half uses aluR[1]). Sign-extend, or zero-extend when loadUnsigned = 1; word loads pass through. For loads, memByteEn is driven as for a store of the same size.
- memAck in IDLE or DONE is ignored.
- Reset, asynchronous and effective immediately: state = IDLE, memReq = 0, memWe = 0, memAddr = 0, memWdata = 0, memByteEn = 0, loadData = 0, busError = 0, counter = 0. A reset in REQ abandons the transaction; a late ack after reset is ignored.

## Timing
- Zero-wait access (ack in the first REQ cycle) takes 3 cycles: T0 IDLE with stall = 1, T1 REQ with memReq = 1 and ack, T2 DONE with stall = 0 and loadData valid. Each extra cycle before ack adds one stall cycle.
- Timeout path: stall stays high for TIMEOUT + 1 cycles (T0 plus TIMEOUT REQ cycles). busError is asserted in the following DONE cycle.
- Back-to-back accesses: the next access is seen in IDLE on the cycle after DONE. No request is issued in DONE.
- A misaligned access or a non-memory instruction adds 0 cycles.
- loadData holds its value until the next load completion or timeout.

## Test plan
- Word load, aluR = 0x0000_1000, memRdata = 0xDEAD_BEEF, ack in T1 -> memReq high only in T1 with memAddr = 0x1000 and memByteEn = 1111; stall = 1,1,0 over T0–T2; loadData = 0xDEAD_BEEF from T2.
- Signed byte load, aluR = 0x1003, memRdata = 0x80xx_xxxx -> loadData = 0xFFFF_FF80. The same access with loadUnsigned = 1 -> loadData = 0x0000_0080.
- Half store, aluR = 0x2002, rt = 0x1234_ABCD, ack after 3 wait cycles -> memWe = 1, memWdata = 0xABCD_ABCD, memByteEn = 1100, all held stable for 4 REQ cycles; stall low only in DONE.
- Word load at aluR = 0x3001 -> addrError = 1, stall = 0, memReq never asserted, loadData unchanged.
- TIMEOUT = 4, load with no ack -> memReq high for exactly 4 cycles; busError = 1 for one cycle (DONE); loadData = 0.
- Reset asserted in the second REQ cycle, ack arriving one cycle later -> memReq drops immediately; state IDLE; ack ignored; all outputs at reset values.
